// File: rtl/dm_sb_csrs.sv
// DMI register front end for system bus access: sbcs, sbaddress0/1 and sbdata0/1,
// plus the start pulses and control fields that feed dm_sba.
module dm_sb_csrs #(
  parameter int BusWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dmactive_i,
  input  logic                req_valid_i,
  input  logic [6:0]          req_addr_i,
  input  logic                req_we_i,
  input  logic [31:0]         req_wdata_i,
  output logic                resp_valid_o,
  output logic [31:0]         resp_rdata_o,
  output logic [BusWidth-1:0] sba_address_o,
  output logic                sba_address_write_valid_o,
  output logic                sba_readonaddr_o,
  output logic                sba_autoincrement_o,
  output logic [2:0]          sba_access_o,
  output logic                sba_readondata_o,
  output logic [BusWidth-1:0] sba_data_o,
  output logic                sba_data_read_valid_o,
  output logic                sba_data_write_valid_o,
  input  logic [BusWidth-1:0] sba_address_i,
  input  logic [BusWidth-1:0] sba_data_i,
  input  logic                sba_data_valid_i,
  input  logic                sba_busy_i,
  input  logic                sba_error_valid_i,
  input  logic [2:0]          sba_error_i
);

  localparam logic [6:0] AddrSbcs  = 7'h38;
  localparam logic [6:0] AddrAddr0 = 7'h39;
  localparam logic [6:0] AddrAddr1 = 7'h3A;
  localparam logic [6:0] AddrData0 = 7'h3C;
  localparam logic [6:0] AddrData1 = 7'h3D;
  localparam logic       Is64      = (BusWidth == 64);
  localparam logic [6:0] SbaSize   = 7'(BusWidth);
  localparam logic [4:0] AccessCap = Is64 ? 5'b01111 : 5'b00111;

  logic                clear;
  logic                busy_error, read_on_addr, auto_inc, read_on_data, read_flag;
  logic [2:0]          access, sb_error;
  logic [BusWidth-1:0] address, data;
  logic [63:0]         address_ext, data_ext;
  logic [31:0]         sbcs, read_mux;
  logic                blocked, err_clear;
  logic                wr_sbcs, wr_addr0, wr_addr1, wr_data0, wr_data1, rd_data0;
  logic                busy_error_set, start_addr, start_rd, start_wr;

  assign clear       = rst_i | ~dmactive_i;
  assign address_ext = 64'(address);
  assign data_ext    = 64'(data);
  assign blocked     = sba_busy_i | busy_error;
  assign err_clear   = (sb_error == 3'd0);

  assign sbcs = {3'd1, 6'd0, busy_error, sba_busy_i, read_on_addr, access,
                 auto_inc, read_on_data, sb_error, SbaSize, AccessCap};

  always_comb begin
    read_mux = '0;
    case (req_addr_i)
      AddrSbcs:  read_mux = sbcs;
      AddrAddr0: read_mux = address_ext[31:0];
      AddrAddr1: read_mux = address_ext[63:32];
      AddrData0: read_mux = data_ext[31:0];
      AddrData1: read_mux = data_ext[63:32];
      default:   read_mux = '0;
    endcase
  end

  // The upper-half registers only exist on a 64-bit bus; otherwise those accesses are inert.
  always_comb begin
    wr_sbcs  = req_valid_i & req_we_i & (req_addr_i == AddrSbcs);
    wr_addr0 = req_valid_i & req_we_i & (req_addr_i == AddrAddr0);
    wr_addr1 = req_valid_i & req_we_i & (req_addr_i == AddrAddr1) & Is64;
    wr_data0 = req_valid_i & req_we_i & (req_addr_i == AddrData0);
    wr_data1 = req_valid_i & req_we_i & (req_addr_i == AddrData1) & Is64;
    rd_data0 = req_valid_i & ~req_we_i & (req_addr_i == AddrData0);
    busy_error_set = blocked & (wr_addr0 | wr_addr1 | wr_data0 | wr_data1 | rd_data0);
    start_addr = wr_addr0 & ~blocked & err_clear & read_on_addr;
    start_wr   = wr_data0 & ~blocked & err_clear;
    start_rd   = rd_data0 & ~blocked & err_clear & read_on_data;
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      busy_error                <= 1'b0;
      read_on_addr              <= 1'b0;
      access                    <= 3'd2;
      auto_inc                  <= 1'b0;
      read_on_data              <= 1'b0;
      sb_error                  <= 3'd0;
      read_flag                 <= 1'b0;
      address                   <= '0;
      data                      <= '0;
      resp_valid_o              <= 1'b0;
      resp_rdata_o              <= '0;
      sba_address_write_valid_o <= 1'b0;
      sba_data_read_valid_o     <= 1'b0;
      sba_data_write_valid_o    <= 1'b0;
    end else begin
      resp_valid_o              <= req_valid_i;
      resp_rdata_o              <= (req_valid_i && !req_we_i) ? read_mux : '0;
      sba_address_write_valid_o <= start_addr;
      sba_data_read_valid_o     <= start_rd;
      sba_data_write_valid_o    <= start_wr;

      if (start_addr || start_rd) read_flag <= 1'b1;
      else if (start_wr)          read_flag <= 1'b0;

      // Hardware-set error flags take priority over a same-cycle W1C.
      busy_error <= (busy_error & ~(wr_sbcs & req_wdata_i[22])) | busy_error_set;
      if (sba_error_valid_i && err_clear) sb_error <= sba_error_i;
      else if (wr_sbcs)                   sb_error <= sb_error & ~req_wdata_i[14:12];

      if (wr_sbcs && !sba_busy_i) begin
        read_on_addr <= req_wdata_i[20];
        access       <= req_wdata_i[19:17];
        auto_inc     <= req_wdata_i[16];
        read_on_data <= req_wdata_i[15];
      end

      if (sba_data_valid_i) begin
        address <= sba_address_i;
        if (read_flag) data <= sba_data_i;
      end

      // A DMI write lands after the engine update so the debugger's value is what sticks.
      if (wr_addr0 && !blocked) address <= BusWidth'({address_ext[63:32], req_wdata_i});
      if (wr_addr1 && !blocked) address <= BusWidth'({req_wdata_i, address_ext[31:0]});
      if (wr_data0 && !blocked) data    <= BusWidth'({data_ext[63:32], req_wdata_i});
      if (wr_data1 && !blocked) data    <= BusWidth'({req_wdata_i, data_ext[31:0]});
    end
  end

  assign sba_address_o       = address;
  assign sba_data_o          = data;
  assign sba_readonaddr_o    = read_on_addr;
  assign sba_autoincrement_o = auto_inc;
  assign sba_access_o        = access;
  assign sba_readondata_o    = read_on_data;

endmodule

// File: tb/tb_dm_sb_csrs.sv
// Bench for dm_sb_csrs: directed scenarios and randomized traffic against a
// register-level reference model of the 32-bit variant, plus a 64-bit instance.
module tb_dm_sb_csrs;

  logic        clk;
  logic        rst_i, dmactive_i;
  logic        req_valid_i, req_we_i;
  logic [6:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic [31:0] sba_address_i, sba_data_i;
  logic        sba_data_valid_i, sba_busy_i, sba_error_valid_i;
  logic [2:0]  sba_error_i;

  logic        resp_valid_o, addr_pulse, rd_pulse, wr_pulse;
  logic [31:0] resp_rdata_o, sba_address_o, sba_data_o;
  logic        roa_o, ainc_o, rod_o;
  logic [2:0]  access_o;

  logic        resp_valid64, addr_pulse64, rd_pulse64, wr_pulse64, roa64, ainc64, rod64;
  logic [31:0] resp_rdata64;
  logic [63:0] address64, data64;
  logic [2:0]  access64;

  int passCount = 0;
  int checkCount = 0;

  // reference model state (32-bit bus)
  bit        mBusyErr, mRoa, mAinc, mRod, mReadFlag;
  bit [2:0]  mAccess, mErr;
  bit [31:0] mAddr, mData;
  bit        expRespValid, expAddrPulse, expRdPulse, expWrPulse;
  bit [31:0] expRdata;

  dm_sb_csrs #(.BusWidth(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .sba_address_o(sba_address_o), .sba_address_write_valid_o(addr_pulse),
    .sba_readonaddr_o(roa_o), .sba_autoincrement_o(ainc_o), .sba_access_o(access_o),
    .sba_readondata_o(rod_o), .sba_data_o(sba_data_o), .sba_data_read_valid_o(rd_pulse),
    .sba_data_write_valid_o(wr_pulse), .sba_address_i(sba_address_i), .sba_data_i(sba_data_i),
    .sba_data_valid_i(sba_data_valid_i), .sba_busy_i(sba_busy_i),
    .sba_error_valid_i(sba_error_valid_i), .sba_error_i(sba_error_i)
  );

  dm_sb_csrs #(.BusWidth(64)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid64), .resp_rdata_o(resp_rdata64),
    .sba_address_o(address64), .sba_address_write_valid_o(addr_pulse64),
    .sba_readonaddr_o(roa64), .sba_autoincrement_o(ainc64), .sba_access_o(access64),
    .sba_readondata_o(rod64), .sba_data_o(data64), .sba_data_read_valid_o(rd_pulse64),
    .sba_data_write_valid_o(wr_pulse64), .sba_address_i({32'd0, sba_address_i}),
    .sba_data_i({32'd0, sba_data_i}), .sba_data_valid_i(sba_data_valid_i),
    .sba_busy_i(sba_busy_i), .sba_error_valid_i(sba_error_valid_i), .sba_error_i(sba_error_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One clock of the register file's documented behaviour, applied to the current inputs.
  function automatic void modelCycle();
    bit [31:0] sbcs, rd;
    bit        blocked, wr, rdReq, nBusyErr;
    bit [2:0]  nErr;
    bit [31:0] nAddr, nData;
    expAddrPulse = 0; expRdPulse = 0; expWrPulse = 0;
    if (rst_i || !dmactive_i) begin
      mBusyErr = 0; mRoa = 0; mAccess = 3'd2; mAinc = 0; mRod = 0; mErr = 0;
      mAddr = 0; mData = 0; mReadFlag = 0; expRespValid = 0; expRdata = 0;
      return;
    end
    sbcs = (32'd1 << 29) + (32'(mBusyErr) << 22) + (32'(sba_busy_i) << 21) + (32'(mRoa) << 20)
         + (32'(mAccess) << 17) + (32'(mAinc) << 16) + (32'(mRod) << 15) + (32'(mErr) << 12)
         + (32'd32 << 5) + 32'd7;
    case (req_addr_i)
      7'h38:   rd = sbcs;
      7'h39:   rd = mAddr;
      7'h3C:   rd = mData;
      default: rd = 0;
    endcase
    wr = req_valid_i && req_we_i;
    rdReq = req_valid_i && !req_we_i;
    expRespValid = req_valid_i;
    expRdata = rdReq ? rd : 32'd0;
    blocked = sba_busy_i || mBusyErr;
    nBusyErr = mBusyErr;
    nErr = mErr;
    nAddr = mAddr;
    nData = mData;
    if (sba_data_valid_i) begin
      nAddr = sba_address_i;
      if (mReadFlag) nData = sba_data_i;
    end
    if (wr && req_addr_i == 7'h38) begin
      if (req_wdata_i[22]) nBusyErr = 0;
      nErr = mErr & ~req_wdata_i[14:12];
      if (!sba_busy_i) begin
        mRoa = req_wdata_i[20]; mAccess = req_wdata_i[19:17];
        mAinc = req_wdata_i[16]; mRod = req_wdata_i[15];
      end
    end
    if (wr && req_addr_i == 7'h39) begin
      if (blocked) nBusyErr = 1;
      else begin
        nAddr = req_wdata_i;
        expAddrPulse = (mErr == 0) && mRoa;
      end
    end
    if (wr && req_addr_i == 7'h3C) begin
      if (blocked) nBusyErr = 1;
      else begin
        nData = req_wdata_i;
        expWrPulse = (mErr == 0);
      end
    end
    if (rdReq && req_addr_i == 7'h3C) begin
      if (blocked) nBusyErr = 1;
      else expRdPulse = mRod && (mErr == 0);
    end
    if (sba_error_valid_i && mErr == 0) nErr = sba_error_i;
    if (expAddrPulse || expRdPulse) mReadFlag = 1;
    else if (expWrPulse) mReadFlag = 0;
    mBusyErr = nBusyErr; mErr = nErr; mAddr = nAddr; mData = nData;
  endfunction

  task automatic applyStimulus(input bit v, input bit [6:0] a, input bit w, input bit [31:0] d);
    req_valid_i = v; req_addr_i = a; req_we_i = w; req_wdata_i = d;
    modelCycle();
    @(posedge clk);
    #1;
    checkOutput("resp_valid", resp_valid_o, expRespValid);
    checkOutput("resp_rdata", resp_rdata_o, expRdata);
    checkOutput("addr_pulse", addr_pulse, expAddrPulse);
    checkOutput("rd_pulse", rd_pulse, expRdPulse);
    checkOutput("wr_pulse", wr_pulse, expWrPulse);
    checkOutput("sba_address", sba_address_o, mAddr);
    checkOutput("sba_data", sba_data_o, mData);
    checkOutput("sbcs_fields", {roa_o, access_o, ainc_o, rod_o}, {mRoa, mAccess, mAinc, mRod});
  endtask

  task automatic idle();
    applyStimulus(0, 7'h00, 0, 32'd0);
  endtask

  bit [6:0] addrTable [7] = '{7'h38, 7'h39, 7'h3A, 7'h3B, 7'h3C, 7'h3D, 7'h10};

  initial begin
    rst_i = 1; dmactive_i = 1;
    req_valid_i = 0; req_addr_i = 0; req_we_i = 0; req_wdata_i = 0;
    sba_address_i = 0; sba_data_i = 0; sba_data_valid_i = 0; sba_busy_i = 0;
    sba_error_valid_i = 0; sba_error_i = 0;
    idle(); idle();
    rst_i = 0;

    applyStimulus(1, 7'h38, 0, 0);
    checkOutput("sbcs_reset_value", resp_rdata_o, 32'h20040407);

    applyStimulus(1, 7'h38, 1, 32'h0010_0000);
    applyStimulus(1, 7'h39, 1, 32'h1000);
    checkOutput("roa_start_pulse", addr_pulse, 1);
    checkOutput("roa_address", sba_address_o, 32'h1000);
    idle();
    checkOutput("roa_pulse_width", addr_pulse, 0);
    sba_data_valid_i = 1; sba_data_i = 32'hCAFE_F00D; sba_address_i = 32'h1004;
    idle();
    sba_data_valid_i = 0;
    applyStimulus(1, 7'h3C, 0, 0);
    checkOutput("read_data_captured", resp_rdata_o, 32'hCAFE_F00D);
    applyStimulus(1, 7'h39, 0, 0);
    checkOutput("next_address", resp_rdata_o, 32'h1004);

    sba_busy_i = 1;
    applyStimulus(1, 7'h3C, 1, 32'h55);
    checkOutput("busy_no_write_pulse", wr_pulse, 0);
    sba_busy_i = 0;
    checkOutput("busy_data_unchanged", sba_data_o, 32'hCAFE_F00D);
    applyStimulus(1, 7'h38, 0, 0);
    checkOutput("busyerror_set", resp_rdata_o[22], 1);
    applyStimulus(1, 7'h38, 1, 32'h0040_0000);
    applyStimulus(1, 7'h38, 0, 0);
    checkOutput("busyerror_w1c", resp_rdata_o[22], 0);

    sba_error_valid_i = 1; sba_error_i = 3'd2;
    idle();
    sba_error_i = 3'd7;
    idle();
    sba_error_valid_i = 0;
    applyStimulus(1, 7'h38, 0, 0);
    checkOutput("sberror_first_wins", resp_rdata_o[14:12], 2);
    applyStimulus(1, 7'h3C, 1, 32'h77);
    checkOutput("sberror_blocks_write", wr_pulse, 0);
    applyStimulus(1, 7'h38, 1, 32'h7000);
    applyStimulus(1, 7'h38, 0, 0);
    checkOutput("sberror_w1c", resp_rdata_o[14:12], 0);

    applyStimulus(1, 7'h38, 1, 32'h8000);
    applyStimulus(1, 7'h3C, 0, 0);
    checkOutput("rod_pulse_1", rd_pulse, 1);
    idle();
    checkOutput("rod_pulse_1_width", rd_pulse, 0);
    applyStimulus(1, 7'h3C, 0, 0);
    checkOutput("rod_pulse_2", rd_pulse, 1);
    applyStimulus(1, 7'h3D, 0, 0);
    checkOutput("sbdata1_no_pulse", rd_pulse, 0);

    dmactive_i = 0;
    applyStimulus(1, 7'h3C, 0, 0);
    checkOutput("dmactive_no_pulse", rd_pulse, 0);
    checkOutput("dmactive_no_resp", resp_valid_o, 0);
    dmactive_i = 1;
    applyStimulus(1, 7'h38, 0, 0);
    checkOutput("dmactive_sbcs", resp_rdata_o, 32'h20040407);
    applyStimulus(1, 7'h3C, 0, 0);
    checkOutput("dmactive_sbdata", resp_rdata_o, 0);

    rst_i = 1;
    idle();
    rst_i = 0;
    applyStimulus(1, 7'h3A, 1, 32'h1);
    applyStimulus(1, 7'h39, 1, 32'h8);
    checkOutput("w64_address", address64, 64'h1_0000_0008);
    applyStimulus(1, 7'h3A, 0, 0);
    checkOutput("w64_read_addr1", resp_rdata64, 32'h1);
    applyStimulus(1, 7'h38, 0, 0);
    checkOutput("w64_sbcs", resp_rdata64, 32'h2004080F);

    for (int i = 0; i < 600; i++) begin
      bit v, w;
      bit [6:0] a;
      rst_i = ($urandom_range(0, 99) == 0);
      dmactive_i = ($urandom_range(0, 99) != 0);
      sba_busy_i = ($urandom_range(0, 3) == 0);
      sba_error_valid_i = ($urandom_range(0, 19) == 0);
      sba_error_i = 3'($urandom);
      sba_data_valid_i = ($urandom_range(0, 7) == 0);
      sba_data_i = $urandom;
      sba_address_i = $urandom;
      v = !sba_data_valid_i && ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 1) == 1);
      a = addrTable[$urandom_range(0, 6)];
      applyStimulus(v, a, w, $urandom);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dm_sb_csrs.md
Name: dm_sb_csrs

Overview:
- DMI-facing register front end for system bus access. Sits directly upstream of dm_sba.
- Holds the sbcs, sbaddress0/1 and sbdata0/1 debug registers and decodes DMI reads and writes to them.
- Generates the start pulses and control fields that dm_sba consumes, and captures its read data, next address and errors.
- Implements the busy-error, sticky-error and W1C rules of the debug spec.

Parameters:
- BusWidth, 32, system bus width. Legal values are 32 and 64. Sets sbasize and the width of the address/data registers.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- dmactive_i  in  1  low = synchronous clear, identical in effect to rst_i
- req_valid_i  in  1  DMI register access, always accepted
- req_addr_i  in  7  DMI register address
- req_we_i  in  1  1 = write, 0 = read
- req_wdata_i  in  32  write data
- resp_valid_o  out  1  response, exactly 1 cycle after req_valid_i
- resp_rdata_o  out  32  read data; 0 for writes and for unmapped addresses
- sba_address_o  out  BusWidth  sbaddress register, to dm_sba sbaddress_i
- sba_address_write_valid_o  out  1  read-on-address start pulse
- sba_readonaddr_o  out  1  sbcs.sbreadonaddr
- sba_autoincrement_o  out  1  sbcs.sbautoincrement
- sba_access_o  out  3  sbcs.sbaccess
- sba_readondata_o  out  1  sbcs.sbreadondata
- sba_data_o  out  BusWidth  sbdata register
- sba_data_read_valid_o  out  1  read-on-data start pulse
- sba_data_write_valid_o  out  1  write start pulse
- sba_address_i  in  BusWidth  next (auto-incremented) address from dm_sba
- sba_data_i  in  BusWidth  bus read data
- sba_data_valid_i  in  1  access completed
- sba_busy_i  in  1  engine busy
- sba_error_valid_i  in  1  error report
- sba_error_i  in  3  error code

Behaviour:
Register map (DMI addresses):
- sbcs = 0x38
- sbaddress0 = 0x39
- sbaddress1 = 0x3A (64-bit only)
- sbdata0 = 0x3C
- sbdata1 = 0x3D (64-bit only)
- When BusWidth = 32, addresses 0x3A and 0x3D read 0 and ignore writes.

sbcs layout:
- [31:29] sbversion = 1
- [22] sbbusyerror, W1C
- [21] sbbusy = sba_busy_i
- [20] sbreadonaddr
- [19:17] sbaccess
- [16] sbautoincrement
- [15] sbreadondata
- [14:12] sberror, W1C
- [11:5] sbasize = BusWidth
- [4:0] = 5'b00111 for 32-bit, 5'b01111 for 64-bit
- All other bits read 0.

Reset (rst_i = 1 or dmactive_i = 0, sampled at the clock edge):
- sbaccess = 2; every other stored field = 0.
- sbaddress = 0, sbdata = 0.
- All pulses, resp_valid_o and resp_rdata_o = 0.
- An in-flight response is dropped.

Read path:
- resp_rdata_o is registered.
- It reflects register state in the request cycle, before any same-cycle hardware update.

"Blocked" is defined as sba_busy_i = 1 or sbbusyerror = 1.

sbcs write:
- W1C bits clear first.
- The config fields (readonaddr, access, autoincrement, readondata) update only when sba_busy_i = 0. Otherwise they are ignored, with no error.

sbaddress0 write:
- If blocked: set sbbusyerror; the register is unchanged.
- Else: update address bits [31:0].
- If additionally sberror = 0 and sbreadonaddr = 1: pulse sba_address_write_valid_o in the next cycle. The new address is visible on sba_address_o in that same cycle.

sbaddress1 write:
- If blocked: set sbbusyerror.
- Else: update address bits [63:32]. No start pulse.

sbdata0 write:
- If blocked: set sbbusyerror.
- Else: update data bits [31:0].
- If additionally sberror = 0: pulse sba_data_write_valid_o in the next cycle, with the new data visible on sba_data_o.

sbdata1 write:
- Updates data bits [63:32] unless blocked (same busy-error rule).

sbdata0 read:
- Returns the current data.
- If blocked: set sbbusyerror; no pulse.
- Else if sbreadondata = 1 and sberror = 0: pulse sba_data_read_valid_o in the next cycle.
- An sbdata1 read never starts an access.

Engine updates:
- On sba_data_valid_i: sbaddress <= sba_address_i.
- If additionally sbaccess was a read: sbdata <= sba_data_i.
- A read is tracked by a 1-bit flag, set by a read start pulse and cleared by a write start pulse.

Errors:
- On sba_error_valid_i with sberror = 0: sberror <= sba_error_i. Errors are sticky; the first error wins.
- A hardware error set in the same cycle as a W1C write to sberror: the set wins.
- A busy-error set in the same cycle as a W1C write to sbbusyerror: the set wins.

Pulses:
- Every start pulse is exactly 1 cycle wide.
- At most one start pulse is asserted per cycle.

Test Plan:
- Reset, then read 0x38 (BusWidth = 32) -> resp_valid_o 1 cycle later, resp_rdata_o = 0x20040407.
- Write sbcs = 0x00100000, then write 0x39 = 0x1000 -> sba_address_o = 0x1000 and sba_address_write_valid_o high for exactly 1 cycle. Then drive sba_data_valid_i with sba_data_i = 0xCAFEF00D and sba_address_i = 0x1004 -> read 0x3C returns 0xCAFEF00D, read 0x39 returns 0x1004.
- Hold sba_busy_i = 1 and write 0x3C = 0x55 -> no pulse, sbdata unchanged, sbcs[22] = 1. Write sbcs bit22 = 1 -> bit22 reads 0.
- Pulse sba_error_valid_i with code 2, then code 7 -> sbcs[14:12] = 2. Write 0x3C -> no write pulse. Write sbcs = 0x7000 -> sberror = 0.
- Set sbreadondata, read 0x3C twice with the engine idle -> two 1-cycle sba_data_read_valid_o pulses. Read 0x3D -> no pulse.
- Drive dmactive_i = 0 for 1 cycle mid-access -> all registers return to reset values and no pulse is emitted. BusWidth = 64: write 0x3A = 0x1 then 0x39 = 0x8 -> sba_address_o = 0x1_0000_0008.
